// File: rtl/cascade_feature_fetcher.sv
// cascade_feature_fetcher
//
// Read-side sequencer for the cascade cache. A start pulse walks the programmed
// cascade stage by stage and classifier by classifier. Each feature is fetched as
// four consecutive cache words. The words are assembled into one record, which is
// then handed to the detection pipeline over valid/ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         begin a walk (IDLE only) / cancel the walk in progress
//   num_stages           stage count, sampled at start
//   stage_sel/stage_len  stage-length lookup (stage_len is combinational from stage_sel)
//   mem_rd_en/mem_addr   cache read strobe and address
//   mem_rdata            cache read data, valid one cycle after mem_rd_en
//   feat_valid/ready     record handshake
//   feat_data            record, word 0 in the LSBs
//   feat_stage           stage index of the record
//   feat_last_in_stage   record is the last classifier of its stage
//   feat_last            record is the last classifier of the last stage
//   busy, done           walk in progress / one-cycle completion pulse
//   err_overrun          sticky: the walk tried to read past WORDS-1, cleared on start
module cascade_feature_fetcher #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned WORDS           = 1024,
  parameter int unsigned STAGE_BITS      = 5,
  parameter int unsigned CLASSIFIER_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [STAGE_BITS-1:0]      num_stages,
  output logic [STAGE_BITS-1:0]      stage_sel,
  input  logic [CLASSIFIER_BITS-1:0] stage_len,
  output logic                       mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [WORD_SIZE-1:0]       mem_rdata,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic [4*WORD_SIZE-1:0]     feat_data,
  output logic [STAGE_BITS-1:0]      feat_stage,
  output logic                       feat_last_in_stage,
  output logic                       feat_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overrun
);

  // One extra bit over a word address: feature_index*4 can reach 2**ADDR_WIDTH
  // after the last legal feature, which must not wrap before the overrun compare.
  localparam int unsigned FidxW = ADDR_WIDTH - 1;

  typedef logic [FidxW-1:0]           fidx_t;
  typedef logic [ADDR_WIDTH:0]        wide_addr_t;
  typedef logic [STAGE_BITS-1:0]      stage_t;
  typedef logic [CLASSIFIER_BITS-1:0] cnt_t;

  localparam wide_addr_t LastWord = wide_addr_t'(WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadStage,
    StFetch,
    StWaitData,
    StPresent,
    StDone
  } state_e;

  state_e state_q, state_d;

  stage_t stage_idx_q, stage_idx_d;
  stage_t num_stages_q, num_stages_d;
  fidx_t  feat_idx_q, feat_idx_d;
  cnt_t   cnt_q, cnt_d;
  logic [1:0] word_q, word_d;
  logic   err_q, err_d;

  // Read-return tracking: data for the read issued this cycle lands next cycle.
  logic       cap_valid_q;
  logic [1:0] cap_slot_q;

  // Registered outputs.
  logic                        mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic                        feat_valid_q, feat_valid_d;
  logic [3:0][WORD_SIZE-1:0]   feat_data_q;
  stage_t                      feat_stage_q, feat_stage_d;
  logic                        last_in_stage_q, last_in_stage_d;
  logic                        last_q, last_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic last_stage;
  logic handshake;

  assign last_stage = (stage_idx_q == num_stages_q - stage_t'(1));
  assign handshake  = feat_valid_q && feat_ready;

  // True when a feature at this index would read past the last valid word.
  function automatic logic overruns(input fidx_t idx);
    wide_addr_t base;
    base = {idx, 2'b00};
    return (base + wide_addr_t'(3)) > LastWord;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and walk counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    stage_idx_d  = stage_idx_q;
    num_stages_d = num_stages_q;
    feat_idx_d   = feat_idx_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          num_stages_d = num_stages;
          err_d        = 1'b0;
          stage_idx_d  = '0;
          feat_idx_d   = '0;
          state_d      = (num_stages == '0) ? StDone : StLoadStage;
        end
      end

      StLoadStage: begin
        cnt_d = stage_len;
        if (stage_len == '0) begin
          // Empty stage: no record, move straight on.
          if (last_stage) begin
            state_d = StDone;
          end else begin
            stage_idx_d = stage_idx_q + stage_t'(1);
          end
        end else if (overruns(feat_idx_q)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          word_d  = 2'd0;
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (word_q == 2'd3) begin
          state_d = StWaitData;
        end else begin
          word_d = word_q + 2'd1;
        end
      end

      StWaitData: begin
        state_d = StPresent;
      end

      StPresent: begin
        if (handshake) begin
          feat_idx_d = feat_idx_q + fidx_t'(1);
          cnt_d      = cnt_q - cnt_t'(1);
          if (cnt_q != cnt_t'(1)) begin
            if (overruns(feat_idx_q + fidx_t'(1))) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              word_d  = 2'd0;
              state_d = StFetch;
            end
          end else if (last_stage) begin
            state_d = StDone;
          end else begin
            stage_idx_d = stage_idx_q + stage_t'(1);
            state_d     = StLoadStage;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything; a concurrent handshake still consumes the record.
    if (abort) begin
      state_d = StIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-values, computed from the next state so outputs stay registered
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd_en_d     = (state_d == StFetch);
    mem_addr_d      = mem_addr_q;
    feat_valid_d    = (state_d == StPresent);
    feat_stage_d    = feat_stage_q;
    last_in_stage_d = last_in_stage_q;
    last_d          = last_q;
    busy_d          = (state_d != StIdle);
    done_d          = (state_d == StDone);

    if (state_d == StFetch) begin
      // The top index bit is always clear while fetching (overrun check passed).
      mem_addr_d = {feat_idx_d[FidxW-2:0], word_d};
    end

    // Record tags are loaded once, on entry to PRESENT, and frozen there.
    if (state_q == StWaitData && state_d == StPresent) begin
      feat_stage_d    = stage_idx_q;
      last_in_stage_d = (cnt_q == cnt_t'(1));
      last_d          = (cnt_q == cnt_t'(1)) && last_stage;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_idx_q     <= '0;
      num_stages_q    <= '0;
      feat_idx_q      <= '0;
      cnt_q           <= '0;
      word_q          <= 2'd0;
      err_q           <= 1'b0;
      cap_valid_q     <= 1'b0;
      cap_slot_q      <= 2'd0;
      mem_rd_en_q     <= 1'b0;
      mem_addr_q      <= '0;
      feat_valid_q    <= 1'b0;
      feat_data_q     <= '0;
      feat_stage_q    <= '0;
      last_in_stage_q <= 1'b0;
      last_q          <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      stage_idx_q     <= stage_idx_d;
      num_stages_q    <= num_stages_d;
      feat_idx_q      <= feat_idx_d;
      cnt_q           <= cnt_d;
      word_q          <= word_d;
      err_q           <= err_d;
      cap_valid_q     <= mem_rd_en_q;
      cap_slot_q      <= mem_addr_q[1:0];
      mem_rd_en_q     <= mem_rd_en_d;
      mem_addr_q      <= mem_addr_d;
      feat_valid_q    <= feat_valid_d;
      feat_stage_q    <= feat_stage_d;
      last_in_stage_q <= last_in_stage_d;
      last_q          <= last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      // Words assemble straight into the output record; no reads are in flight
      // while PRESENT, so the record is stable during backpressure.
      if (cap_valid_q) begin
        feat_data_q[cap_slot_q] <= mem_rdata;
      end
    end
  end

  assign stage_sel          = stage_idx_q;
  assign mem_rd_en          = mem_rd_en_q;
  assign mem_addr           = mem_addr_q;
  assign feat_valid         = feat_valid_q;
  assign feat_data          = feat_data_q;
  assign feat_stage         = feat_stage_q;
  assign feat_last_in_stage = last_in_stage_q;
  assign feat_last          = last_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_overrun        = err_q;

endmodule
